// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM power-up initialisation sequencer.
// SDRAM_INIT_EMRS_EN adds the extended-mode-register states.
package sdram_pkg;

    // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_PRE   = 4'd1;
    localparam logic [3:0] ST_TRP   = 4'd2;
    localparam logic [3:0] ST_AR    = 4'd3;
    localparam logic [3:0] ST_TRFC  = 4'd4;
    localparam logic [3:0] ST_MRS   = 4'd5;
    localparam logic [3:0] ST_TMRD  = 4'd6;
    localparam logic [3:0] ST_END   = 4'd7;
`ifdef SDRAM_INIT_EMRS_EN
    localparam logic [3:0] ST_EMRS  = 4'd8;
    localparam logic [3:0] ST_TEMRD = 4'd9;
`endif

    // Largest of four wait lengths, used to size the shared wait counter
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_wait_cnt.sv
// Loadable down-counter shared by every wait state of the init sequencer.
// done is high while the count sits at 1, i.e. on the last wait cycle.
module sdram_wait_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done,
    output logic         idle
);

    logic [W-1:0] cnt;

    // Load on request, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == W'(1));
    assign idle = (cnt == '0);

endmodule

// File: rtl/sdram_init_gen.sv
// SDRAM power-up initialisation sequencer: power-up wait, precharge-all,
// AR_NUM auto-refreshes, mode register load, then done. init_req in END
// re-runs the sequence from precharge. Define SDRAM_INIT_EMRS_EN to also
// load the extended mode register after the mode register.
//
// state  | meaning
// IDLE   | power-up wait, NOP for T_POWERUP cycles
// PRE    | PRECHARGE all banks (addr[10]=1)
// TRP    | wait out T_RP
// AR     | AUTO_REFRESH
// TRFC   | wait out T_RFC, then next AR or MRS
// MRS    | LOAD_MODE with MODE_VAL
// TMRD   | wait out T_MRD
// EMRS   | LOAD_MODE bank 2'b10 with EMR_VAL (SDRAM_INIT_EMRS_EN only)
// TEMRD  | wait out T_MRD (SDRAM_INIT_EMRS_EN only)
// END    | sequence complete, init_end high
module sdram_init_gen
    import sdram_pkg::*;
#(
    parameter int                ADDR_W    = 13,
    parameter int                BANK_W    = 2,
    parameter int                T_POWERUP = 20000,
    parameter int                T_RP      = 2,
    parameter int                T_RFC     = 7,
    parameter int                T_MRD     = 2,
    parameter int                AR_NUM    = 8,
    parameter logic [ADDR_W-1:0] MODE_VAL  = 'h032,
    parameter logic [ADDR_W-1:0] EMR_VAL   = 'h000
) (
    input  logic              init_clk,
    input  logic              init_rst,
    input  logic              init_req,
    output logic              init_cke,
    output logic [3:0]        init_cmd,
    output logic [BANK_W-1:0] init_bank,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_end
);

    localparam int CNT_MAX = max_of4(T_POWERUP, T_RP, T_RFC, T_MRD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int AR_W    = $clog2(AR_NUM + 1);

    logic [3:0]        state, nxt;
    logic [AR_W-1:0]   ar_cnt;
    logic              cnt_load, cnt_done, cnt_idle;
    logic [CNT_W-1:0]  cnt_val;
    logic [3:0]        cmd_d;
    logic [BANK_W-1:0] bank_d;
    logic [ADDR_W-1:0] addr_d;

`ifndef SDRAM_INIT_EMRS_EN
    // EMR_VAL has no consumer when the extended register is not loaded
    logic unused_emr;
    assign unused_emr = ^EMR_VAL;
`endif

    sdram_wait_cnt #(
        .W (CNT_W)
    ) u_wait_cnt (
        .clk      (init_clk),
        .rst      (init_rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done),
        .idle     (cnt_idle)
    );

    // Next state and wait-counter loads; wait states last T-1 cycles so the
    // following command lands exactly T cycles after the previous one
    always_comb begin
        nxt      = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_IDLE: begin
                if (cnt_done) begin
                    nxt = ST_PRE;
                end else if (cnt_idle) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(T_POWERUP);
                end
            end
            ST_PRE: begin
                nxt      = ST_TRP;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(T_RP - 1);
            end
            ST_TRP: begin
                if (cnt_done) nxt = ST_AR;
            end
            ST_AR: begin
                nxt      = ST_TRFC;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(T_RFC - 1);
            end
            ST_TRFC: begin
                if (cnt_done) nxt = (ar_cnt == AR_W'(AR_NUM)) ? ST_MRS : ST_AR;
            end
            ST_MRS: begin
                nxt      = ST_TMRD;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(T_MRD - 1);
            end
            ST_TMRD: begin
`ifdef SDRAM_INIT_EMRS_EN
                if (cnt_done) nxt = ST_EMRS;
`else
                if (cnt_done) nxt = ST_END;
`endif
            end
`ifdef SDRAM_INIT_EMRS_EN
            ST_EMRS: begin
                nxt      = ST_TEMRD;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(T_MRD - 1);
            end
            ST_TEMRD: begin
                if (cnt_done) nxt = ST_END;
            end
`endif
            ST_END: begin
                if (init_req) nxt = ST_PRE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, registered below
    always_comb begin
        cmd_d  = CMD_NOP;
        bank_d = '0;
        addr_d = '0;
        case (nxt)
            ST_PRE: begin
                cmd_d      = CMD_PRECHARGE;
                addr_d[10] = 1'b1;
            end
            ST_AR: cmd_d = CMD_AUTO_REFRESH;
            ST_MRS: begin
                cmd_d  = CMD_LOAD_MODE;
                addr_d = MODE_VAL;
            end
`ifdef SDRAM_INIT_EMRS_EN
            ST_EMRS: begin
                cmd_d  = CMD_LOAD_MODE;
                bank_d = BANK_W'(2);
                addr_d = EMR_VAL;
            end
`endif
            default: ;
        endcase
    end

    // State, refresh count and registered outputs
    always_ff @(posedge init_clk) begin
        if (init_rst) begin
            state     <= ST_IDLE;
            ar_cnt    <= '0;
            init_cke  <= 1'b0;
            init_cmd  <= CMD_NOP;
            init_bank <= '0;
            init_addr <= '0;
            init_end  <= 1'b0;
        end else begin
            state     <= nxt;
            init_cke  <= 1'b1;
            init_cmd  <= cmd_d;
            init_bank <= bank_d;
            init_addr <= addr_d;
            init_end  <= (nxt == ST_END);
            if (nxt == ST_PRE) begin
                ar_cnt <= '0;
            end else if (nxt == ST_AR) begin
                ar_cnt <= ar_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_init_gen.sv
// Scoreboard bench for sdram_init_gen: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
// Expectations follow SDRAM_INIT_EMRS_EN when it is defined.
module tb_sdram_init_gen;
    import sdram_pkg::*;

    localparam logic [12:0] MODE = 13'h032;
    localparam logic [12:0] EMR  = 13'h0A5;
`ifdef SDRAM_INIT_EMRS_EN
    localparam int END_R = 20;
`else
    localparam int END_R = 18;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        cke;
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] addr;
    logic        fin;

    sdram_init_gen #(
        .ADDR_W    (13),
        .BANK_W    (2),
        .T_POWERUP (10),
        .T_RP      (2),
        .T_RFC     (7),
        .T_MRD     (2),
        .AR_NUM    (2),
        .MODE_VAL  (MODE),
        .EMR_VAL   (EMR)
    ) dut (
        .init_clk  (clk),
        .init_rst  (rst),
        .init_req  (req),
        .init_cke  (cke),
        .init_cmd  (cmd),
        .init_bank (bank),
        .init_addr (addr),
        .init_end  (fin)
    );

    always #5 clk = ~clk;

    int tick = 0;
    always @(posedge clk) tick <= tick + 1;

    typedef struct {
        int          tick;
        logic [3:0]  cmd;
        logic [1:0]  bank;
        logic [12:0] addr;
        logic        cke;
        logic        fin;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void push_exp(input int t, input logic [3:0] c, input logic [1:0] b,
                                     input logic [12:0] a, input logic k, input logic f,
                                     input string n);
        exp_t e;
        e.tick = t; e.cmd = c; e.bank = b; e.addr = a; e.cke = k; e.fin = f; e.name = n;
        exp_q.push_back(e);
    endfunction

    // Cycles c_from..c_to of a run whose PRECHARGE falls on cycle pre_c
    function automatic void push_run(input int base, input int pre_c, input int c_from,
                                     input int c_to, input string tag);
        for (int c = c_from; c <= c_to; c++) begin
            int          r;
            logic [3:0]  ec;
            logic [1:0]  eb;
            logic [12:0] ea;
            r  = c - pre_c;
            ec = CMD_NOP; eb = 2'b00; ea = 13'h0000;
            if (r == 0) begin
                ec = CMD_PRECHARGE; ea = 13'h0400;
            end else if (r == 2 || r == 9) begin
                ec = CMD_AUTO_REFRESH;
            end else if (r == 16) begin
                ec = CMD_LOAD_MODE; ea = MODE;
            end
`ifdef SDRAM_INIT_EMRS_EN
            else if (r == 18) begin
                ec = CMD_LOAD_MODE; eb = 2'b10; ea = EMR;
            end
`endif
            push_exp(base + c, ec, eb, ea, 1'b1, (r >= END_R), $sformatf("%s_c%0d", tag, c));
        end
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset for n edges expecting reset outputs; base is cycle 0 after release
    task automatic do_reset(input int n, input string tag, output int base);
        rst = 1'b1;
        for (int i = 1; i <= n; i++)
            push_exp(tick + i, CMD_NOP, 2'b00, 13'h0000, 1'b0, 1'b0, $sformatf("%s_%0d", tag, i));
        wait_cycles(n);
        rst  = 1'b0;
        base = tick + 1;
    endtask

    // Monitor: compare every expectation due at this cycle
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].tick <= tick) begin
            e = exp_q.pop_front();
            checks++;
            if (e.tick != tick || cmd !== e.cmd || bank !== e.bank || addr !== e.addr ||
                cke !== e.cke || fin !== e.fin) begin
                errors++;
                $display("FAIL %s (tick %0d/%0d): got cmd=%b bank=%b addr=%h cke=%b end=%b, want cmd=%b bank=%b addr=%h cke=%b end=%b",
                         e.name, tick, e.tick, cmd, bank, addr, cke, fin,
                         e.cmd, e.bank, e.addr, e.cke, e.fin);
            end
        end
    end

    initial begin
        int base;
        rst = 1'b1;
        req = 1'b0;

        // Nominal sequence, then a re-run request after END
        do_reset(3, "reset_a", base);
        push_run(base, 10, 0, 40, "nominal");
        wait_cycles(41);
        req = 1'b1;
        push_run(base, 41, 41, 70, "rerun");
        wait_cycles(1);
        req = 1'b0;
        wait_cycles(29);

        // Request mid-sequence must be ignored
        do_reset(2, "reset_b", base);
        push_run(base, 10, 0, 35, "req_ignored");
        wait_cycles(16);
        req = 1'b1;
        wait_cycles(1);
        req = 1'b0;
        wait_cycles(19);

        // Reset mid-sequence restarts the full power-up wait
        do_reset(2, "reset_c", base);
        push_run(base, 10, 0, 19, "pre_rst");
        wait_cycles(20);
        do_reset(2, "mid_rst", base);
        push_run(base, 10, 0, 35, "post_rst");
        wait_cycles(36);

        wait_cycles(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
